demux_1x4_stream: RTL and testbench
===================================

// Module: demux_1x4_stream
// PURPOSE
//  1-to-4 stream demultiplexer: the inverse of the 4x1 2-bit mux. Routes each
//  input beat to one of four output channels, chosen by sel. Each output has a
//  one-entry registered buffer and a valid/ready handshake.
//  The channel is latched at the first beat of a packet and held until in_last.
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  WIDTH      2  data bits per beat
//  PKT_CNT_W  8  width of each per-channel completed-packet counter
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            synchronous reset, active low
//  in_data    in   WIDTH        input beat data
//  in_valid   in   1            input beat present
//  in_last    in   1            beat is the final beat of its packet
//  in_ready   out  1            block accepts beat this cycle
//  sel        in   2            target channel, sampled on first beat of a packet
//  out_data   out  4*WIDTH      channel i data = out_data[i*WIDTH +: WIDTH]
//  out_valid  out  4            channel i buffer holds a beat
//  out_last   out  4            channel i buffered beat is the last beat
//  out_ready  in   4            channel i consumer accepts
//  busy       out  1            1 while a multi-beat packet is in progress (state PKT)
//  cur_sel    out  2            locked channel (valid while busy)
//  pkt_cnt    out  4*PKT_CNT_W  per-channel count of accepted last beats
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, out_last=0, out_data=0,
//    pkt_cnt=0, state=IDLE, cur_sel=0, busy=0. Buffered beats are discarded.
//    Reset mid-packet aborts the packet; no partial-packet recovery.
//  - FSM: IDLE, PKT. busy = (state==PKT).
//    Target channel: tgt = IDLE ? sel : cur_sel.
//  - in_ready = !out_valid[tgt] | out_ready[tgt]. This is combinational from
//    state, sel and out_ready. There is no combinational path from in_valid.
//  - acc = in_valid & in_ready. On acc, in the next cycle:
//    out_data[tgt] = in_data, out_last[tgt] = in_last, out_valid[tgt] = 1.
//    Latency is 1 cycle.
//  - FSM transitions:
//    IDLE, acc and !in_last -> PKT, cur_sel <= sel.
//    IDLE, acc and in_last  -> stay IDLE (single-beat packet).
//    PKT, acc and in_last   -> IDLE. cur_sel keeps its value.
//    No acc -> no change.
//  - sel is ignored while in PKT. Changing sel mid-packet has no effect.
//  - Channel i drain: out_valid[i] & out_ready[i] with no new load to i
//    -> out_valid[i] <= 0. out_data and out_last hold their values.
//    Drain and load of the same channel in the same cycle: the new beat replaces
//    the old one and out_valid stays 1. This gives 1 beat/cycle per channel.
//  - Non-target channels drain independently of input activity.
//  - pkt_cnt[i] += 1 on acc with in_last and tgt==i. It wraps (2^PKT_CNT_W-1 -> 0).
//  - in_valid=0: no state change except channel drains.
//    in_data, in_last and sel are don't-care when in_valid=0.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clk with in_valid=1
//    -> out_valid=0, busy=0, pkt_cnt=0, no beat accepted.
//  2 Single beat: sel=2, in_data=2'b11, in_last=1, out_ready=4'b1111
//    -> next cycle out_valid=4'b0100, ch2 data=11, out_last[2]=1,
//       pkt_cnt[2]=1, busy stays 0.
//  3 Lock: 3-beat packet with sel=1 on beat 0, sel=3 on beats 1-2
//    -> all 3 beats appear on ch1, busy=1 for 2 cycles, then IDLE.
//  4 Backpressure: out_ready[0]=0 with ch0 full
//    -> in_ready=0 for tgt=0, beat held, ch0 data unchanged.
//    Raise out_ready[0]=1 -> in_ready=1, back-to-back beats at 1/cycle.
//  5 Reset mid-packet: rst_n=0 after beat 1 of a 4-beat packet on ch3
//    -> out_valid=0, busy=0. The next packet honours the new sel.
//  6 Wrap: 256 single-beat packets to ch0 with PKT_CNT_W=8 -> pkt_cnt[0]=0.

Source files
------------

// File: rtl/demux_1x4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x4_stream_if
//  Purpose  : Bundles the producer-side stream, the four consumer channels and
//             the status outputs of the 1-to-4 stream demultiplexer.
//  Ports    : in_data/in_valid/in_last/in_ready/sel   producer stream
//             out_data/out_valid/out_last/out_ready   four consumer channels
//             busy/cur_sel/pkt_cnt                     status
//  Modports : master - environment side (drives stream, consumes channels)
//             slave  - demultiplexer side
//  Revision : 1.0 - initial release
// ============================================================================
interface demux_1x4_stream_if #(
  parameter int WIDTH     = 2,
  parameter int PKT_CNT_W = 8
);
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [1:0]             sel;
  logic [4*WIDTH-1:0]     out_data;
  logic [3:0]             out_valid;
  logic [3:0]             out_last;
  logic [3:0]             out_ready;
  logic                   busy;
  logic [1:0]             cur_sel;
  logic [4*PKT_CNT_W-1:0] pkt_cnt;

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, cur_sel, pkt_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, cur_sel, pkt_cnt
  );
endinterface
`default_nettype wire

// File: rtl/demux_1x4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x4_stream
//  Purpose  : 1-to-4 stream demultiplexer. Each accepted beat is written into
//             a one-entry buffer of the channel chosen by sel; the channel is
//             locked on the first beat of a packet and held until in_last.
//             Per-channel counters track completed packets.
//  Ports    : clk    rising-edge clock
//             rst_n  synchronous reset, active low
//             bus    stream/channel/status bundle (slave modport)
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1x4_stream #(
  parameter int WIDTH     = 2,
  parameter int PKT_CNT_W = 8
) (
  input  wire                     clk,
  input  wire                     rst_n,
  demux_1x4_stream_if.slave       bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam logic [PKT_CNT_W-1:0] CNT_ONE = {{(PKT_CNT_W-1){1'b0}}, 1'b1};

  state_t                         state_q,     state_d;
  logic [1:0]                     cur_sel_q,   cur_sel_d;
  logic [3:0]                     out_valid_q, out_valid_d;
  logic [3:0]                     out_last_q,  out_last_d;
  logic [3:0][WIDTH-1:0]          out_data_q,  out_data_d;
  logic [3:0][PKT_CNT_W-1:0]      pkt_cnt_q,   pkt_cnt_d;

  logic [1:0] tgt;
  logic       in_ready;
  logic       acc;

  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    pkt_cnt_d   = pkt_cnt_q;

    // Outside a packet the live sel picks the channel; inside, the locked one.
    tgt      = (state_q == IDLE) ? bus.sel : cur_sel_q;
    // Depends only on state, sel and out_ready -- never on in_valid.
    in_ready = !out_valid_q[tgt] | bus.out_ready[tgt];
    acc      = bus.in_valid & in_ready;

    // Every channel drains on its own; a load below overrides the drain so a
    // channel can pass one beat per cycle.
    for (int i = 0; i < 4; i++) begin
      if (out_valid_q[i] && bus.out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end

    if (acc) begin
      out_data_d[tgt]  = bus.in_data;
      out_last_d[tgt]  = bus.in_last;
      out_valid_d[tgt] = 1'b1;
      if (bus.in_last) begin
        pkt_cnt_d[tgt] = pkt_cnt_q[tgt] + CNT_ONE;
      end
    end

    case (state_q)
      IDLE: begin
        if (acc && !bus.in_last) begin
          state_d   = PKT;
          cur_sel_d = bus.sel;
        end
      end
      PKT: begin
        if (acc && bus.in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_sel_q   <= 2'b00;
      out_valid_q <= 4'b0000;
      out_last_q  <= 4'b0000;
      out_data_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == PKT);
  assign bus.cur_sel   = cur_sel_q;
  assign bus.pkt_cnt   = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1x4_stream
//  Purpose  : Directed, table-driven bench for demux_1x4_stream. Inputs are
//             applied on the falling edge; in_ready is sampled before the
//             rising edge and registered outputs 1 ns after it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x4_stream;

  logic clk;
  logic rst_n;

  demux_1x4_stream_if #(.WIDTH(2), .PKT_CNT_W(8)) bus ();

  demux_1x4_stream #(.WIDTH(2), .PKT_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_data;
    logic        in_last;
    logic [1:0]  sel;
    logic [3:0]  out_ready;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [3:0]  exp_ol;
    logic [7:0]  exp_od;
    logic        exp_busy;
    logic [1:0]  exp_cs;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] d,
                       input logic l, input logic [1:0] s, input logic [3:0] ordy);
    rst_n         = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.sel       = s;
    bus.out_ready = ordy;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'hF);

    //             rst v  d  l  sel ordy chk rdy  ov    ol    od     bsy cs  pc
    // Reset held two cycles with in_valid high
    tbl[0]  = '{1'b0,1'b1,2'd3,1'b1,2'd2,4'hF,1'b0,1'b0,4'b0000,4'b0000,8'h00,1'b0,2'd0,32'h0000_0000};
    tbl[1]  = '{1'b0,1'b1,2'd3,1'b1,2'd2,4'hF,1'b1,1'b1,4'b0000,4'b0000,8'h00,1'b0,2'd0,32'h0000_0000};
    // Single-beat packet to ch2, then idle drain
    tbl[2]  = '{1'b1,1'b1,2'd3,1'b1,2'd2,4'hF,1'b1,1'b1,4'b0100,4'b0100,8'h30,1'b0,2'd0,32'h0001_0000};
    tbl[3]  = '{1'b1,1'b0,2'd0,1'b0,2'd0,4'hF,1'b1,1'b1,4'b0000,4'b0100,8'h30,1'b0,2'd0,32'h0001_0000};
    // 3-beat packet locked to ch1 though sel moves to 3
    tbl[4]  = '{1'b1,1'b1,2'd1,1'b0,2'd1,4'hF,1'b1,1'b1,4'b0010,4'b0100,8'h34,1'b1,2'd1,32'h0001_0000};
    tbl[5]  = '{1'b1,1'b1,2'd2,1'b0,2'd3,4'hF,1'b1,1'b1,4'b0010,4'b0100,8'h38,1'b1,2'd1,32'h0001_0000};
    tbl[6]  = '{1'b1,1'b1,2'd3,1'b1,2'd3,4'hF,1'b1,1'b1,4'b0010,4'b0110,8'h3C,1'b0,2'd1,32'h0001_0100};
    tbl[7]  = '{1'b1,1'b0,2'd0,1'b0,2'd0,4'hF,1'b1,1'b1,4'b0000,4'b0110,8'h3C,1'b0,2'd1,32'h0001_0100};
    // Backpressure on ch0, then release with back-to-back beats
    tbl[8]  = '{1'b1,1'b1,2'd2,1'b1,2'd0,4'hE,1'b1,1'b1,4'b0001,4'b0111,8'h3E,1'b0,2'd1,32'h0001_0101};
    tbl[9]  = '{1'b1,1'b1,2'd1,1'b1,2'd0,4'hE,1'b1,1'b0,4'b0001,4'b0111,8'h3E,1'b0,2'd1,32'h0001_0101};
    tbl[10] = '{1'b1,1'b1,2'd1,1'b0,2'd0,4'hF,1'b1,1'b1,4'b0001,4'b0110,8'h3D,1'b1,2'd0,32'h0001_0101};
    tbl[11] = '{1'b1,1'b1,2'd3,1'b1,2'd2,4'hF,1'b1,1'b1,4'b0001,4'b0111,8'h3F,1'b0,2'd0,32'h0001_0102};
    // 4-beat packet on ch3 aborted by reset after its second beat
    tbl[12] = '{1'b1,1'b1,2'd1,1'b0,2'd3,4'h0,1'b1,1'b1,4'b1001,4'b0111,8'h7F,1'b1,2'd3,32'h0001_0102};
    tbl[13] = '{1'b1,1'b1,2'd2,1'b0,2'd0,4'hF,1'b1,1'b1,4'b1000,4'b0111,8'hBF,1'b1,2'd3,32'h0001_0102};
    tbl[14] = '{1'b0,1'b1,2'd3,1'b0,2'd1,4'hF,1'b1,1'b1,4'b0000,4'b0000,8'h00,1'b0,2'd0,32'h0000_0000};
    tbl[15] = '{1'b1,1'b1,2'd2,1'b1,2'd1,4'hF,1'b1,1'b1,4'b0010,4'b0010,8'h08,1'b0,2'd0,32'h0000_0100};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].in_valid, tbl[i].in_data, tbl[i].in_last,
            tbl[i].sel, tbl[i].out_ready);
      #1;
      if (tbl[i].chk_rdy)
        check($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].exp_ov});
      check($sformatf("v%0d out_last", i),  {28'd0, bus.out_last},  {28'd0, tbl[i].exp_ol});
      check($sformatf("v%0d out_data", i),  {24'd0, bus.out_data},  {24'd0, tbl[i].exp_od});
      check($sformatf("v%0d busy", i),      {31'd0, bus.busy},      {31'd0, tbl[i].exp_busy});
      check($sformatf("v%0d cur_sel", i),   {30'd0, bus.cur_sel},   {30'd0, tbl[i].exp_cs});
      check($sformatf("v%0d pkt_cnt", i),   bus.pkt_cnt,            tbl[i].exp_pc);
    end

    // 256 single-beat packets to ch0 at one beat per cycle: counter wraps to 0
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, k[1:0], 1'b1, 2'd0, 4'hF);
      #1;
      check($sformatf("wrap%0d in_ready", k), {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (k == 254)
        check("wrap pkt_cnt 255", bus.pkt_cnt, 32'h0000_01FF);
    end
    check("wrap pkt_cnt 0",    bus.pkt_cnt,  32'h0000_0100);
    check("wrap out_valid",    {28'd0, bus.out_valid}, 32'h1);
    check("wrap out_data ch0", {30'd0, bus.out_data[1:0]}, 32'd3);

    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'hF);
    @(posedge clk);
    #1;
    check("final drain out_valid", {28'd0, bus.out_valid}, 32'h0);
    check("final busy", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
